// File: rtl/tx_char_sched.sv
// Transmit character scheduler for a SpaceWire-style link.
//
// Picks the next character to hand to the encoder with strict priority
// (TCODE > FCT > DATA > NULL). It also tracks the N-char credit granted by
// remote FCTs and the count of FCTs owed to the remote end.
//
// Ports:
//   pclk_tx           clock; all logic runs on its rising edge
//   reset_tx          synchronous active-high reset; overrides everything
//   enable_tx         link enabled; low aborts any character and clears state
//   send_null_tx      NULL transmission permitted
//   send_fct_tx       FCT transmission permitted
//   run_tx            link in Run; N-chars and time-codes permitted
//   gotfct_tx         pulse: remote FCT received (+8 credit)
//   fct_req           pulse: local receiver freed 8 slots (one more FCT owed)
//   txwrite_tx        level: host has an N-char pending
//   tickin_tx         level: host has a time-code pending
//   char_done         pulse: encoder finished the current character
//   char_start        pulse: launch the character on sel_char
//   sel_char          0=IDLE 1=NULL 2=FCT 3=DATA 4=TCODE, stable while busy
//   ready_tx_data     pulse with char_start when DATA is launched
//   ready_tx_timecode pulse with char_start when TCODE is launched
//   credit_cnt        current N-char credits
//   credit_error      pulse the cycle after a credit overflow is detected
module tx_char_sched #(
    parameter int unsigned MAX_CREDIT   = 56,
    parameter int unsigned MAX_FCT_PEND = 7
) (
    input  logic       pclk_tx,
    input  logic       reset_tx,
    input  logic       enable_tx,
    input  logic       send_null_tx,
    input  logic       send_fct_tx,
    input  logic       run_tx,
    input  logic       gotfct_tx,
    input  logic       fct_req,
    input  logic       txwrite_tx,
    input  logic       tickin_tx,
    input  logic       char_done,
    output logic       char_start,
    output logic [2:0] sel_char,
    output logic       ready_tx_data,
    output logic       ready_tx_timecode,
    output logic [5:0] credit_cnt,
    output logic       credit_error
);

    localparam int unsigned PEND_W = (MAX_FCT_PEND < 2) ? 1 : $clog2(MAX_FCT_PEND + 1);
    localparam logic [PEND_W-1:0] PEND_MAX   = PEND_W'(MAX_FCT_PEND);
    localparam logic [6:0]        CREDIT_MAX = 7'(MAX_CREDIT);

    localparam logic [2:0] SEL_IDLE  = 3'd0;
    localparam logic [2:0] SEL_NULL  = 3'd1;
    localparam logic [2:0] SEL_FCT   = 3'd2;
    localparam logic [2:0] SEL_DATA  = 3'd3;
    localparam logic [2:0] SEL_TCODE = 3'd4;

    typedef enum logic {StIdle, StBusy} state_t;

    state_t            state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic              start_q, start_d;
    logic              rdy_data_q, rdy_data_d;
    logic              rdy_tc_q, rdy_tc_d;
    logic [5:0]        credit_q, credit_d;
    logic              err_q, err_d;
    logic [PEND_W-1:0] pend_q, pend_d;

    logic [2:0]        pick;
    logic              launch_fct;
    logic              launch_data;
    logic [6:0]        credit_sum;

    // Highest-priority eligible character this cycle.
    always_comb begin
        pick = SEL_IDLE;
        if (tickin_tx && run_tx) begin
            pick = SEL_TCODE;
        end else if ((pend_q != '0) && send_fct_tx) begin
            pick = SEL_FCT;
        end else if (txwrite_tx && run_tx && (credit_q != 6'd0)) begin
            pick = SEL_DATA;
        end else if (send_null_tx) begin
            pick = SEL_NULL;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        start_d    = 1'b0;
        rdy_data_d = 1'b0;
        rdy_tc_d   = 1'b0;
        case (state_q)
            StIdle: begin
                sel_d = SEL_IDLE;
                if (pick != SEL_IDLE) begin
                    state_d    = StBusy;
                    sel_d      = pick;
                    start_d    = 1'b1;
                    rdy_data_d = (pick == SEL_DATA);
                    rdy_tc_d   = (pick == SEL_TCODE);
                end
            end
            StBusy: begin
                // New requests are ignored until the encoder reports done.
                if (char_done) begin
                    state_d = StIdle;
                    sel_d   = SEL_IDLE;
                end
            end
            default: begin
                state_d = StIdle;
                sel_d   = SEL_IDLE;
            end
        endcase
    end

    assign launch_fct  = (state_q == StIdle) && (pick == SEL_FCT);
    assign launch_data = (state_q == StIdle) && (pick == SEL_DATA);

    // Credit: +8 per remote FCT, -1 per DATA launch. An overflowing +8 is
    // dropped but the debit still applies.
    always_comb begin
        credit_sum = {1'b0, credit_q} + (gotfct_tx ? 7'd8 : 7'd0) - {6'd0, launch_data};
        credit_d   = credit_sum[5:0];
        err_d      = 1'b0;
        if (gotfct_tx && (credit_sum > CREDIT_MAX)) begin
            credit_d = credit_q - {5'd0, launch_data};
            err_d    = 1'b1;
        end
    end

    // Pending FCTs: saturating increment on fct_req, decrement on FCT launch;
    // both in the same cycle cancel out.
    always_comb begin
        pend_d = pend_q;
        if (launch_fct && !fct_req) begin
            pend_d = pend_q - PEND_W'(1);
        end else if (fct_req && !launch_fct && (pend_q != PEND_MAX)) begin
            pend_d = pend_q + PEND_W'(1);
        end
    end

    // Disabling the link clears state exactly like reset, aborting any
    // character in flight.
    always_ff @(posedge pclk_tx) begin
        if (reset_tx || !enable_tx) begin
            state_q    <= StIdle;
            sel_q      <= SEL_IDLE;
            start_q    <= 1'b0;
            rdy_data_q <= 1'b0;
            rdy_tc_q   <= 1'b0;
            credit_q   <= 6'd0;
            err_q      <= 1'b0;
            pend_q     <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            start_q    <= start_d;
            rdy_data_q <= rdy_data_d;
            rdy_tc_q   <= rdy_tc_d;
            credit_q   <= credit_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
        end
    end

    assign char_start        = start_q;
    assign sel_char          = sel_q;
    assign ready_tx_data     = rdy_data_q;
    assign ready_tx_timecode = rdy_tc_q;
    assign credit_cnt        = credit_q;
    assign credit_error      = err_q;

endmodule

// File: tb/tb_tx_char_sched.sv
// Directed bench for tx_char_sched. Expected launches are queued when the
// stimulus is set up and popped when char_start is seen.
module tb_tx_char_sched;

    logic       clk;
    logic       reset_tx, enable_tx, send_null_tx, send_fct_tx, run_tx;
    logic       gotfct_tx, fct_req, txwrite_tx, tickin_tx, char_done;
    logic       char_start, ready_tx_data, ready_tx_timecode, credit_error;
    logic [2:0] sel_char;
    logic [5:0] credit_cnt;

    typedef struct packed {
        logic [2:0] sel;
        logic       rd;
        logic       rt;
    } exp_t;

    exp_t       sb_q[$];
    logic [2:0] last_sel;
    int         checks = 0;
    int         errors = 0;

    tx_char_sched #(.MAX_CREDIT(56), .MAX_FCT_PEND(7)) dut (
        .pclk_tx           (clk),
        .reset_tx          (reset_tx),
        .enable_tx         (enable_tx),
        .send_null_tx      (send_null_tx),
        .send_fct_tx       (send_fct_tx),
        .run_tx            (run_tx),
        .gotfct_tx         (gotfct_tx),
        .fct_req           (fct_req),
        .txwrite_tx        (txwrite_tx),
        .tickin_tx         (tickin_tx),
        .char_done         (char_done),
        .char_start        (char_start),
        .sel_char          (sel_char),
        .ready_tx_data     (ready_tx_data),
        .ready_tx_timecode (ready_tx_timecode),
        .credit_cnt        (credit_cnt),
        .credit_error      (credit_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] sel);
        exp_t e;
        e.sel = sel;
        e.rd  = (sel == 3'd3);
        e.rt  = (sel == 3'd4);
        sb_q.push_back(e);
    endtask

    // Step until char_start (bounded), then compare against the queue head.
    task automatic wait_start();
        int   n;
        exp_t e;
        n = 0;
        do begin
            step();
            n++;
        end while (char_start !== 1'b1 && n < 20);
        check("launch", 32'(char_start), 32'd1);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty observed launch expected none");
            last_sel = sel_char;
        end else begin
            e = sb_q.pop_front();
            last_sel = e.sel;
            check("sel", 32'(sel_char), 32'(e.sel));
            check("rdy_data", 32'(ready_tx_data), 32'(e.rd));
            check("rdy_tc", 32'(ready_tx_timecode), 32'(e.rt));
        end
    endtask

    // One busy cycle, then char_done; ends in IDLE before the next edge.
    task automatic finish_char();
        step();
        check("start_pulse", 32'(char_start), 32'd0);
        check("sel_hold", 32'(sel_char), 32'(last_sel));
        check("rdy_data_low", 32'(ready_tx_data), 32'd0);
        check("rdy_tc_low", 32'(ready_tx_timecode), 32'd0);
        check("err_low", 32'(credit_error), 32'd0);
        char_done = 1'b1;
        step();
        char_done = 1'b0;
        check("sel_after_done", 32'(sel_char), 32'd0);
    endtask

    task automatic expect_launch();
        wait_start();
        finish_char();
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("quiet_start", 32'(char_start), 32'd0);
            check("quiet_sel", 32'(sel_char), 32'd0);
        end
    endtask

    initial begin
        reset_tx = 1'b1; enable_tx = 1'b0; send_null_tx = 1'b0; send_fct_tx = 1'b0;
        run_tx = 1'b0; gotfct_tx = 1'b0; fct_req = 1'b0; txwrite_tx = 1'b0;
        tickin_tx = 1'b0; char_done = 1'b0; last_sel = 3'd0;
        step();
        step();
        check("rst_sel", 32'(sel_char), 32'd0);
        check("rst_start", 32'(char_start), 32'd0);
        check("rst_rdy_data", 32'(ready_tx_data), 32'd0);
        check("rst_rdy_tc", 32'(ready_tx_timecode), 32'd0);
        check("rst_credit", 32'(credit_cnt), 32'd0);
        check("rst_err", 32'(credit_error), 32'd0);

        // Reset beats enable and requests.
        enable_tx = 1'b1; send_null_tx = 1'b1; gotfct_tx = 1'b1;
        step();
        check("rst_ovr_start", 32'(char_start), 32'd0);
        check("rst_ovr_credit", 32'(credit_cnt), 32'd0);
        reset_tx = 1'b0; gotfct_tx = 1'b0; send_null_tx = 1'b0;
        quiet(2);

        // Credit gating: no credit -> NULL only, then +8 allows DATA.
        run_tx = 1'b1; txwrite_tx = 1'b1; send_null_tx = 1'b1;
        push(3'd1);
        expect_launch();
        push(3'd1);
        expect_launch();
        txwrite_tx = 1'b0; send_null_tx = 1'b0; gotfct_tx = 1'b1;
        step();
        gotfct_tx = 1'b0;
        check("credit_8", 32'(credit_cnt), 32'd8);
        check("idle_start", 32'(char_start), 32'd0);
        check("idle_sel", 32'(sel_char), 32'd0);
        txwrite_tx = 1'b1; send_null_tx = 1'b1;
        push(3'd3);
        expect_launch();
        check("credit_7", 32'(credit_cnt), 32'd7);
        txwrite_tx = 1'b0; send_null_tx = 1'b0;

        // Priority: pending=2, credit=7, everything requested.
        fct_req = 1'b1;
        step();
        step();
        fct_req = 1'b0;
        quiet(1);
        tickin_tx = 1'b1; txwrite_tx = 1'b1; send_fct_tx = 1'b1; send_null_tx = 1'b1;
        push(3'd4);
        expect_launch();
        tickin_tx = 1'b0;
        push(3'd2);
        expect_launch();
        push(3'd2);
        expect_launch();
        push(3'd3);
        expect_launch();
        txwrite_tx = 1'b0; send_null_tx = 1'b0; send_fct_tx = 1'b0;
        check("credit_6", 32'(credit_cnt), 32'd6);

        // fct_req coinciding with an FCT launch leaves pending unchanged.
        fct_req = 1'b1;
        step();
        fct_req = 1'b1; send_fct_tx = 1'b1;
        push(3'd2);
        wait_start();
        fct_req = 1'b0;
        finish_char();
        push(3'd2);
        expect_launch();
        quiet(4);
        send_fct_tx = 1'b0;

        // Credit overflow.
        gotfct_tx = 1'b1;
        for (int i = 0; i < 6; i++) step();
        gotfct_tx = 1'b0;
        check("credit_54", 32'(credit_cnt), 32'd54);
        txwrite_tx = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(3'd3);
            expect_launch();
        end
        txwrite_tx = 1'b0;
        check("credit_50", 32'(credit_cnt), 32'd50);
        gotfct_tx = 1'b1;
        step();
        gotfct_tx = 1'b0;
        check("ovf_credit", 32'(credit_cnt), 32'd50);
        check("ovf_err", 32'(credit_error), 32'd1);
        step();
        check("ovf_err_once", 32'(credit_error), 32'd0);
        check("ovf_credit_hold", 32'(credit_cnt), 32'd50);
        txwrite_tx = 1'b1;
        push(3'd3);
        expect_launch();
        check("credit_49", 32'(credit_cnt), 32'd49);
        gotfct_tx = 1'b1;
        push(3'd3);
        wait_start();
        gotfct_tx = 1'b0; txwrite_tx = 1'b0;
        check("credit_56", 32'(credit_cnt), 32'd56);
        finish_char();

        // Pending saturation at 7.
        fct_req = 1'b1;
        for (int i = 0; i < 9; i++) step();
        fct_req = 1'b0;
        send_fct_tx = 1'b1;
        for (int i = 0; i < 7; i++) begin
            push(3'd2);
            expect_launch();
        end
        quiet(5);
        send_fct_tx = 1'b0;

        // Abort mid-DATA.
        txwrite_tx = 1'b1;
        push(3'd3);
        wait_start();
        check("abort_pre_credit", 32'(credit_cnt), 32'd55);
        txwrite_tx = 1'b0; enable_tx = 1'b0;
        step();
        check("abort_sel", 32'(sel_char), 32'd0);
        check("abort_credit", 32'(credit_cnt), 32'd0);
        check("abort_start", 32'(char_start), 32'd0);
        gotfct_tx = 1'b1; send_null_tx = 1'b1;
        step();
        gotfct_tx = 1'b0;
        check("dis_credit", 32'(credit_cnt), 32'd0);
        check("dis_err", 32'(credit_error), 32'd0);
        check("dis_start", 32'(char_start), 32'd0);
        send_null_tx = 1'b0; enable_tx = 1'b1; char_done = 1'b1;
        step();
        char_done = 1'b0;
        check("late_done_start", 32'(char_start), 32'd0);
        check("late_done_sel", 32'(sel_char), 32'd0);
        send_null_tx = 1'b1;
        push(3'd1);
        expect_launch();
        send_null_tx = 1'b0;

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
